alu_op_sequencer: RTL and testbench

Front-end controller for the 7-bit ALU on the FPGA board.
- Replaces direct switch-to-ALU wiring with a three-press entry sequence over the shared switch bank: operand A, then operand B, then opcode.
- Holds the ALU inputs stable, waits a settle interval, and latches the result and flags.
- Drives the display value, blanking and stage LEDs.
- Supports chained operation, where the previous result becomes the next operand A.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_op_sequencer_edge_pulse.sv | 29 ++
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU operand sequencer.
//                Covers the state/stage encoding and the default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DEFAULT_DATA_W      = 7;
    localparam int DEFAULT_OP_W        = 2;
    localparam int DEFAULT_FLAG_W      = 5;
    localparam int DEFAULT_EXEC_CYCLES = 2;

    // Stage codes shown on the board LEDs; the FSM state uses the same encoding.
    localparam logic [2:0] STAGE_LOAD_A  = 3'd0;
    localparam logic [2:0] STAGE_LOAD_B  = 3'd1;
    localparam logic [2:0] STAGE_LOAD_OP = 3'd2;
    localparam logic [2:0] STAGE_EXEC    = 3'd3;
    localparam logic [2:0] STAGE_SHOW    = 3'd4;

    typedef enum logic [2:0] {
        LOAD_A  = STAGE_LOAD_A,
        LOAD_B  = STAGE_LOAD_B,
        LOAD_OP = STAGE_LOAD_OP,
        EXEC    = STAGE_EXEC,
        SHOW    = STAGE_SHOW
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse
//  Description : One-cycle pulse on the rising edge of a debounced level.
//                History register clears to 0 in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic r_prev;

    // Remember last cycle's level so a held button fires only once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    assign pulse = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Three-press operand/opcode entry front end for the board ALU.
//                Holds ALU inputs, waits a settle interval, latches the result
//                and flags, drives the display and stage LEDs, and supports
//                chaining the previous result into operand A.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int OP_W        = DEFAULT_OP_W,
    parameter int FLAG_W      = DEFAULT_FLAG_W,
    parameter int EXEC_CYCLES = DEFAULT_EXEC_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic              chain_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W:0]   alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [DATA_W:0]   result_q,
    output logic [FLAG_W-1:0] flags_q,
    output logic              result_valid,
    output logic              busy,
    output logic [2:0]        stage,
    output logic [DATA_W:0]   disp_value,
    output logic              disp_blank
);

    // Counter only has to hold EXEC_CYCLES-1; keep at least one bit.
    localparam int            CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    seq_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt;
    logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
    logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
    logic [DATA_W:0]   r_result, w_result_nxt;
    logic [FLAG_W-1:0] r_flags, w_flags_nxt;
    logic              r_valid, w_valid_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic w_enter_press;
    logic w_clear_press;

    // Upper switches beyond the operand field are not used by this block.
    logic w_unused_sw;
    assign w_unused_sw = ^sw[15:DATA_W];

    edge_pulse u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_enter),
        .pulse (w_enter_press)
    );

    edge_pulse u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_clear),
        .pulse (w_clear_press)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= LOAD_A;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_alu_a  <= w_alu_a_nxt;
            r_alu_b  <= w_alu_b_nxt;
            r_alu_op <= w_alu_op_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_valid  <= w_valid_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state and datapath updates; clear overrides everything, including EXEC.
    always_comb begin
        w_state_nxt  = r_state;
        w_alu_a_nxt  = r_alu_a;
        w_alu_b_nxt  = r_alu_b;
        w_alu_op_nxt = r_alu_op;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_valid_nxt  = r_valid;
        w_cnt_nxt    = r_cnt;

        if (w_clear_press) begin
            w_state_nxt  = LOAD_A;
            w_alu_a_nxt  = '0;
            w_alu_b_nxt  = '0;
            w_alu_op_nxt = '0;
            w_result_nxt = '0;
            w_flags_nxt  = '0;
            w_valid_nxt  = 1'b0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_enter_press) begin
                        w_alu_a_nxt = sw[DATA_W-1:0];
                        w_state_nxt = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_enter_press) begin
                        w_alu_b_nxt = sw[DATA_W-1:0];
                        w_state_nxt = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (w_enter_press) begin
                        w_alu_op_nxt = sw[OP_W-1:0];
                        w_cnt_nxt    = CNT_LOAD;
                        w_state_nxt  = EXEC;
                    end
                end
                EXEC: begin
                    // Enter presses are dropped here while the ALU settles.
                    if (r_cnt == '0) begin
                        w_result_nxt = alu_result;
                        w_flags_nxt  = alu_flags;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = SHOW;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (w_enter_press) begin
                        if (chain_en) begin
                            // Result MSB (carry) does not fit an operand.
                            w_alu_a_nxt = r_result[DATA_W-1:0];
                            w_state_nxt = LOAD_B;
                        end else begin
                            w_valid_nxt = 1'b0;
                            w_state_nxt = LOAD_A;
                        end
                    end
                end
                default: begin
                    w_state_nxt = LOAD_A;
                end
            endcase
        end
    end

    // Display source: live switch preview while loading, result in SHOW.
    always_comb begin
        disp_value = '0;
        case (r_state)
            LOAD_A, LOAD_B, LOAD_OP: disp_value = {1'b0, sw[DATA_W-1:0]};
            SHOW:                    disp_value = r_result;
            default:                 disp_value = '0;
        endcase
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign result_q     = r_result;
    assign flags_q      = r_flags;
    assign result_valid = r_valid;
    assign busy         = (r_state == EXEC);
    assign disp_blank   = (r_state == EXEC);
    assign stage        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                stubbed ALU driven straight from the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        btn_enter;
    logic        btn_clear;
    logic        chain_en;
    logic [6:0]  alu_a;
    logic [6:0]  alu_b;
    logic [1:0]  alu_op;
    logic [7:0]  alu_result;
    logic [4:0]  alu_flags;
    logic [7:0]  result_q;
    logic [4:0]  flags_q;
    logic        result_valid;
    logic        busy;
    logic [2:0]  stage;
    logic [7:0]  disp_value;
    logic        disp_blank;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .chain_en     (chain_en),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .result_q     (result_q),
        .flags_q      (flags_q),
        .result_valid (result_valid),
        .busy         (busy),
        .stage        (stage),
        .disp_value   (disp_value),
        .disp_blank   (disp_blank)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enter press: high for one edge, then low for one edge.
    task automatic press();
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sw = '0; btn_enter = 1'b0; btn_clear = 1'b0; chain_en = 1'b0;
        alu_result = '0; alu_flags = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_stage", 32'(stage), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_blank", 32'(disp_blank), 0);
        chk("rst_result", 32'(result_q), 0);

        // Operand A / B / opcode entry
        sw = 16'h0005; press();
        chk("a_val", 32'(alu_a), 32'h05);
        chk("a_stage", 32'(stage), 1);
        sw = 16'h0003; #1;
        chk("preview_b", 32'(disp_value), 32'h03);
        press();
        chk("b_val", 32'(alu_b), 32'h03);
        chk("b_stage", 32'(stage), 2);
        alu_result = 8'h08; alu_flags = 5'b00001; sw = 16'h0000;
        btn_enter = 1'b1; tick();
        chk("op_stage", 32'(stage), 3);
        chk("op_busy", 32'(busy), 1);
        chk("op_blank", 32'(disp_blank), 1);
        chk("op_disp", 32'(disp_value), 0);
        chk("op_val", 32'(alu_op), 0);
        btn_enter = 1'b0; tick();
        chk("exec1_stage", 32'(stage), 3);
        chk("exec1_valid", 32'(result_valid), 0);
        tick();
        chk("show_stage", 32'(stage), 4);
        chk("show_result", 32'(result_q), 32'h08);
        chk("show_flags", 32'(flags_q), 32'h01);
        chk("show_valid", 32'(result_valid), 1);
        chk("show_disp", 32'(disp_value), 32'h08);
        chk("show_busy", 32'(busy), 0);

        // Chain 0x08 into A, then compute 0x88 and chain again (MSB dropped)
        chain_en = 1'b1; press();
        chk("chain1_stage", 32'(stage), 1);
        chk("chain1_a", 32'(alu_a), 32'h08);
        chk("chain1_valid", 32'(result_valid), 1);
        sw = 16'h0012; press();
        chk("b2_val", 32'(alu_b), 32'h12);
        alu_result = 8'h88; alu_flags = 5'h1A; sw = 16'hABCD;
        press(); tick();
        chk("op2_val", 32'(alu_op), 1);
        chk("r2_result", 32'(result_q), 32'h88);
        chk("r2_flags", 32'(flags_q), 32'h1A);
        chk("r2_disp", 32'(disp_value), 32'h88);
        press();
        chk("chain2_stage", 32'(stage), 1);
        chk("chain2_a", 32'(alu_a), 32'h08);
        chk("chain2_valid", 32'(result_valid), 1);

        // Enter pressed during EXEC is ignored and not queued
        sw = 16'h0044; press();
        alu_result = 8'h5A; alu_flags = 5'h03; sw = 16'h0002;
        btn_enter = 1'b1; tick();
        chk("op3_stage", 32'(stage), 3);
        btn_enter = 1'b0; tick();
        btn_enter = 1'b1; tick();
        chk("exec_press_stage", 32'(stage), 4);
        chk("exec_press_result", 32'(result_q), 32'h5A);
        tick();
        chk("exec_press_noqueue", 32'(stage), 4);
        btn_enter = 1'b0; tick();

        // Non-chained exit from SHOW
        chain_en = 1'b0; press();
        chk("nochain_stage", 32'(stage), 0);
        chk("nochain_valid", 32'(result_valid), 0);
        chk("nochain_a_kept", 32'(alu_a), 32'h08);
        chk("nochain_op_kept", 32'(alu_op), 2);

        // Enter held for 20 cycles; switches changing meanwhile are ignored
        sw = 16'h0011; btn_enter = 1'b1; tick();
        sw = 16'h0022;
        repeat (19) tick();
        btn_enter = 1'b0; tick();
        chk("held_stage", 32'(stage), 1);
        chk("held_a", 32'(alu_a), 32'h11);

        // Clear and enter rising together in LOAD_B
        sw = 16'h0033; btn_enter = 1'b1; btn_clear = 1'b1; tick();
        btn_enter = 1'b0; btn_clear = 1'b0; tick();
        chk("clr_en_stage", 32'(stage), 0);
        chk("clr_en_b", 32'(alu_b), 0);
        chk("clr_en_a", 32'(alu_a), 0);
        chk("clr_en_result", 32'(result_q), 0);

        // Clear in the first EXEC cycle aborts without latching
        sw = 16'h0001; press();
        sw = 16'h0002; press();
        alu_result = 8'h55; alu_flags = 5'h15; sw = 16'h0003;
        btn_enter = 1'b1; tick();
        btn_enter = 1'b0; btn_clear = 1'b1; tick();
        chk("clr_exec_stage", 32'(stage), 0);
        chk("clr_exec_a", 32'(alu_a), 0);
        chk("clr_exec_b", 32'(alu_b), 0);
        chk("clr_exec_op", 32'(alu_op), 0);
        chk("clr_exec_valid", 32'(result_valid), 0);
        chk("clr_exec_busy", 32'(busy), 0);
        btn_clear = 1'b0; tick(); tick();
        chk("clr_exec_nolatch", 32'(result_q), 0);
        chk("clr_exec_noflags", 32'(flags_q), 0);
        chk("clr_exec_idle", 32'(stage), 0);

        // Reach SHOW with 0x7F, then reset with enter held
        sw = 16'h0010; press();
        sw = 16'h0020; press();
        alu_result = 8'h7F; alu_flags = 5'h1F; sw = 16'h0003;
        press(); tick();
        chk("pre_rst_stage", 32'(stage), 4);
        chk("pre_rst_result", 32'(result_q), 32'h7F);
        sw = 16'h0009; reset = 1'b1; btn_enter = 1'b1; tick();
        chk("rst2_stage", 32'(stage), 0);
        chk("rst2_result", 32'(result_q), 0);
        chk("rst2_flags", 32'(flags_q), 0);
        chk("rst2_a", 32'(alu_a), 0);
        chk("rst2_b", 32'(alu_b), 0);
        chk("rst2_op", 32'(alu_op), 0);
        chk("rst2_valid", 32'(result_valid), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_blank", 32'(disp_blank), 0);
        chk("rst2_disp", 32'(disp_value), 32'h09);
        tick();
        reset = 1'b0; btn_enter = 1'b0; tick();
        chk("post_rst_idle", 32'(stage), 0);
        btn_enter = 1'b1; tick();
        btn_enter = 1'b0; tick();
        chk("post_rst_stage", 32'(stage), 1);
        chk("post_rst_a", 32'(alu_a), 32'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
